// File: rtl/byte_fetch_sequencer.sv
// Byte-serial fetch sequencer: reads BYTES consecutive bytes from a latched PC and assembles them into a word.
// Build option: define BYTE_SEQ_BIG_ENDIAN_EN to place the first-fetched byte in the MSB lane.
module byte_fetch_sequencer #(
  parameter  int N     = 32,
  parameter  int BYTES = 4,
  localparam int CW    = $clog2(BYTES)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [N-1:0]       i_pc,
  input  logic [7:0]         i_mem_data,
  input  logic               i_mem_ready,
  output logic [N-1:0]       o_addr,
  output logic               o_rd,
  output logic [CW-1:0]      o_count,
  output logic [8*BYTES-1:0] o_word,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  state_t                  state_q, state_d;
  logic [N-1:0]            base_q,  base_d;
  logic [CW-1:0]           count_q, count_d;
  logic [BYTES-1:0][7:0]   asm_q,   asm_d;
  logic [BYTES-1:0][7:0]   asm_ins;
  logic [8*BYTES-1:0]      word_q,  word_d;
  logic [CW-1:0]           slot;

  // Byte lane that the current beat lands in.
`ifdef BYTE_SEQ_BIG_ENDIAN_EN
  assign slot = LAST - count_q;
`else
  assign slot = count_q;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    asm_d   = asm_q;
    word_d  = word_q;

    // Assembly including the byte on the bus; the final beat publishes this directly.
    asm_ins       = asm_q;
    asm_ins[slot] = i_mem_data;

    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (i_start) begin
          base_d  = i_pc;
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (i_mem_ready) begin
          asm_d = asm_ins;
          if (count_q == LAST) begin
            word_d  = asm_ins;
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end

      DONE: state_d = IDLE;

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      count_q <= '0;
      // NOTE: the assembly register is small and reset explicitly, so an abandoned fetch leaves no stale bytes.
      asm_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      asm_q   <= asm_d;
      word_q  <= word_d;
    end
  end

  // Address wraps modulo 2^N by plain truncation of the sum.
  assign o_addr  = base_q + N'(count_q);
  assign o_count = count_q;
  assign o_word  = word_q;
  assign o_rd    = (state_q == FETCH);
  assign o_busy  = (state_q != IDLE);
  assign o_done  = (state_q == DONE);

endmodule

// File: tb/tb_byte_fetch_sequencer.sv
// Directed bench for byte_fetch_sequencer: BYTES=4 main instance plus BYTES=2 and BYTES=8 sweep instances.
// Expected words follow BYTE_SEQ_BIG_ENDIAN_EN when the bench is built with it.
module tb_byte_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start4, ready4, rd4, busy4, done4;
  logic [31:0] pc4, addr4, word4;
  logic [7:0]  data4;
  logic [1:0]  count4;

  logic        start2, ready2, rd2, busy2, done2;
  logic [31:0] pc2, addr2;
  logic [15:0] word2;
  logic [7:0]  data2;
  logic [0:0]  count2;

  logic        start8, ready8, rd8, busy8, done8;
  logic [31:0] pc8, addr8;
  logic [63:0] word8;
  logic [7:0]  data8;
  logic [2:0]  count8;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_last4;

  byte_fetch_sequencer #(.N(32), .BYTES(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_pc(pc4),
    .i_mem_data(data4), .i_mem_ready(ready4),
    .o_addr(addr4), .o_rd(rd4), .o_count(count4), .o_word(word4),
    .o_busy(busy4), .o_done(done4)
  );

  byte_fetch_sequencer #(.N(32), .BYTES(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_pc(pc2),
    .i_mem_data(data2), .i_mem_ready(ready2),
    .o_addr(addr2), .o_rd(rd2), .o_count(count2), .o_word(word2),
    .o_busy(busy2), .o_done(done2)
  );

  byte_fetch_sequencer #(.N(32), .BYTES(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_pc(pc8),
    .i_mem_data(data8), .i_mem_ready(ready8),
    .o_addr(addr8), .o_rd(rd8), .o_count(count8), .o_word(word8),
    .o_busy(busy8), .o_done(done8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One BYTES=4 fetch. bytes_le holds memory byte k in bits [8k+7:8k].
  // wait_at/wait_n insert ready-low cycles at that count; poke_at pulses i_start (pc 0x200) in that cycle.
  task automatic fetch4(input string name, input logic [31:0] pc, input logic [31:0] bytes_le,
                        input int wait_at, input int wait_n, input int poke_at);
    logic [31:0] exp_word;
    int k, waits, cyc;
`ifdef BYTE_SEQ_BIG_ENDIAN_EN
    exp_word = {bytes_le[7:0], bytes_le[15:8], bytes_le[23:16], bytes_le[31:24]};
`else
    exp_word = bytes_le;
`endif
    start4 = 1'b1; pc4 = pc; ready4 = 1'b0;
    tick();
    start4 = 1'b0; pc4 = 32'h0BAD_0BAD;
    k = 0; waits = 0; cyc = 1;
    while (k < 4) begin
      checks++;
      if ({addr4, count4, rd4, busy4, done4, word4} !== {pc + 32'(k), 2'(k), 3'b110, exp_last4}) begin
        failures++;
        $display("FAIL %s_beat_c%0d got addr=%h count=%0d rd_busy_done=%b%b%b word=%h want addr=%h count=%0d rd_busy_done=110 word=%h",
                 name, cyc, addr4, count4, rd4, busy4, done4, word4, pc + 32'(k), k, exp_last4);
      end
      if (k == wait_at && waits < wait_n) begin
        ready4 = 1'b0; data4 = 8'hEE; waits++;
      end else begin
        ready4 = 1'b1; data4 = bytes_le[8*k +: 8]; k++;
      end
      if (cyc == poke_at) begin start4 = 1'b1; pc4 = 32'h200; end
      tick();
      start4 = 1'b0;
      cyc++;
    end
    ready4 = 1'b0;
    exp_last4 = exp_word;
    checks++;
    if ({done4, busy4, rd4, count4, word4} !== {3'b110, 2'd0, exp_word}) begin
      failures++;
      $display("FAIL %s_done_c%0d got done_busy_rd=%b%b%b count=%0d word=%h want done_busy_rd=110 count=0 word=%h",
               name, cyc, done4, busy4, rd4, count4, word4, exp_word);
    end
    if (cyc == poke_at) begin start4 = 1'b1; pc4 = 32'h300; end
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({done4, busy4, rd4, count4, word4} !== {3'b000, 2'd0, exp_word}) begin
        failures++;
        $display("FAIL %s_idle%0d got done_busy_rd=%b%b%b count=%0d word=%h want done_busy_rd=000 count=0 word=%h",
                 name, i, done4, busy4, rd4, count4, word4, exp_word);
      end
      if (i == 0) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start4 = 1'b0; pc4 = '0; data4 = '0; ready4 = 1'b0;
    start2 = 1'b0; pc2 = '0; data2 = '0; ready2 = 1'b0;
    start8 = 1'b0; pc8 = '0; data8 = '0; ready8 = 1'b0;
    exp_last4 = '0;
    tick(); tick();
    checks++;
    if ({addr4, count4, rd4, busy4, done4, word4} !== '0) begin
      failures++;
      $display("FAIL reset_dut4 got addr=%h count=%0d rd_busy_done=%b%b%b word=%h want all zero",
               addr4, count4, rd4, busy4, done4, word4);
    end
    checks++;
    if ({addr2, count2, rd2, busy2, done2, word2} !== '0) begin
      failures++;
      $display("FAIL reset_dut2 got addr=%h word=%h rd_busy_done=%b%b%b want all zero", addr2, word2, rd2, busy2, done2);
    end
    checks++;
    if ({addr8, count8, rd8, busy8, done8, word8} !== '0) begin
      failures++;
      $display("FAIL reset_dut8 got addr=%h word=%h rd_busy_done=%b%b%b want all zero", addr8, word8, rd8, busy8, done8);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    fetch4("basic", 32'h100, 32'h4433_2211, -1, 0, -1);
  endtask

  task automatic test_wait_states();
    fetch4("wait", 32'h100, 32'hD4C3_B2A1, 2, 2, -1);
  endtask

  task automatic test_wrap();
    fetch4("wrap", 32'hFFFF_FFFE, 32'h5A6B_7C8D, -1, 0, -1);
  endtask

  task automatic test_start_while_busy();
    fetch4("busy_start", 32'h100, 32'h0F1E_2D3C, -1, 0, 2);
  endtask

  task automatic test_back_to_back();
    // Start raised in the DONE cycle must be dropped; the next fetch then starts straight from IDLE.
    fetch4("b2b_a", 32'h400, 32'h8899_AABB, -1, 0, 5);
    fetch4("b2b_b", 32'h404, 32'h1357_9BDF, -1, 0, -1);
  endtask

  task automatic test_reset_mid_fetch();
    bit saw_done;
    start4 = 1'b1; pc4 = 32'h100;
    tick();
    start4 = 1'b0;
    ready4 = 1'b1; data4 = 8'h11; tick();
    data4 = 8'h22; tick();
    checks++;
    if ({count4, addr4, rd4} !== {2'd2, 32'h102, 1'b1}) begin
      failures++;
      $display("FAIL midrst_pre got count=%0d addr=%h rd=%b want count=2 addr=00000102 rd=1", count4, addr4, rd4);
    end
    rst = 1'b1; data4 = 8'h33;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({addr4, count4, rd4, busy4, done4, word4} !== '0) begin
        failures++;
        $display("FAIL midrst_hold%0d got addr=%h count=%0d rd_busy_done=%b%b%b word=%h want all zero",
                 i, addr4, count4, rd4, busy4, done4, word4);
      end
    end
    rst = 1'b0;
    exp_last4 = '0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done4 || busy4) saw_done = 1'b1;
    end
    ready4 = 1'b0;
    checks++;
    if ({saw_done, word4} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL midrst_after got activity=%b word=%h want activity=0 word=00000000", saw_done, word4);
    end
  endtask

  task automatic test_param_sweep();
    logic [15:0] exp2;
    logic [63:0] exp8;
`ifdef BYTE_SEQ_BIG_ENDIAN_EN
    exp2 = 16'hA1B2;
    exp8 = 64'h0102_0304_0506_0708;
`else
    exp2 = 16'hB2A1;
    exp8 = 64'h0807_0605_0403_0201;
`endif
    start2 = 1'b1; pc2 = 32'h10;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({addr2, count2, rd2, busy2, done2} !== {32'h10 + 32'(k), 1'(k), 3'b110}) begin
        failures++;
        $display("FAIL sweep2_beat%0d got addr=%h count=%0d rd_busy_done=%b%b%b want addr=%h count=%0d rd_busy_done=110",
                 k, addr2, count2, rd2, busy2, done2, 32'h10 + 32'(k), k);
      end
      ready2 = 1'b1; data2 = (k == 0) ? 8'hA1 : 8'hB2;
      tick();
    end
    ready2 = 1'b0;
    checks++;
    if ({done2, busy2, rd2, word2} !== {3'b110, exp2}) begin
      failures++;
      $display("FAIL sweep2_done_c3 got done_busy_rd=%b%b%b word=%h want 110 word=%h", done2, busy2, rd2, word2, exp2);
    end
    tick();

    start8 = 1'b1; pc8 = 32'h20;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({addr8, count8, rd8, busy8, done8} !== {32'h20 + 32'(k), 3'(k), 3'b110}) begin
        failures++;
        $display("FAIL sweep8_beat%0d got addr=%h count=%0d rd_busy_done=%b%b%b want addr=%h count=%0d rd_busy_done=110",
                 k, addr8, count8, rd8, busy8, done8, 32'h20 + 32'(k), k);
      end
      ready8 = 1'b1; data8 = 8'(k + 1);
      tick();
    end
    ready8 = 1'b0;
    checks++;
    if ({done8, busy8, rd8, word8} !== {3'b110, exp8}) begin
      failures++;
      $display("FAIL sweep8_done_c9 got done_busy_rd=%b%b%b word=%h want 110 word=%h", done8, busy8, rd8, word8, exp8);
    end
    tick();
    checks++;
    if ({done8, busy8, word8} !== {2'b00, exp8}) begin
      failures++;
      $display("FAIL sweep8_idle got done_busy=%b%b word=%h want 00 word=%h", done8, busy8, word8, exp8);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_wrap();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_fetch();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
